conv5_window_gen: RTL and testbench

//  Upstream feeder for the 5x5 convolution neuron. Accepts a raster-order pixel

---
 rtl/conv5_window_gen_if.sv | 29 ++
 rtl/conv5_window_gen.sv | 87 ++++++++
 tb/tb_conv5_window_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv5_window_gen_if.sv
// Pixel-in / window-out bundle for the 5x5 window generator.
// pix_valid qualifies pix_in; there is no ready, so a pixel is taken on every
// cycle that pix_valid is high. win_valid is a one-cycle strobe with no ready:
// the sink takes win_flat (and frame_done) on that cycle or loses it.
interface conv5_window_gen_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0]    pix_in;
    logic                 pix_valid;
    logic [25*DATA_W-1:0] win_flat;
    logic                 win_valid;
    logic                 frame_done;

    modport master (
        output pix_in,
        output pix_valid,
        input  win_flat,
        input  win_valid,
        input  frame_done
    );

    modport slave (
        input  pix_in,
        input  pix_valid,
        output win_flat,
        output win_valid,
        output frame_done
    );
endinterface

// File: rtl/conv5_window_gen.sv
// Raster pixel stream -> 5x5 neighbourhood windows, using four row-deep line
// buffers and a 5x5 shift register; one window per qualifying pixel.
module conv5_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    conv5_window_gen_if.slave   bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(4);
    localparam logic [RW-1:0] ROW_MIN  = RW'(4);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] lb3 [IMG_W];

    logic [DATA_W-1:0]    win [25];
    logic [25*DATA_W-1:0] win_flat_r;
    logic                 win_valid_r;
    logic                 frame_done_r;

    // Line buffers are plain RAM: never reset, only read back after rewrite.
    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            lb0[col] <= bus.pix_in;
            lb1[col] <= lb0[col];
            lb2[col] <= lb1[col];
            lb3[col] <= lb2[col];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col          <= '0;
            row          <= '0;
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            for (int k = 0; k < 25; k++) begin
                win[k] <= '0;
            end
        end else begin
            win_valid_r  <= bus.pix_valid && (row >= ROW_MIN) && (col >= COL_MIN);
            frame_done_r <= bus.pix_valid && (row == ROW_LAST) && (col == COL_LAST);
            if (bus.pix_valid) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        win[r*5+c] <= win[r*5+c+1];
                    end
                end
                // Rightmost column, oldest row at the top.
                win[4]  <= lb3[col];
                win[9]  <= lb2[col];
                win[14] <= lb1[col];
                win[19] <= lb0[col];
                win[24] <= bus.pix_in;
            end
        end
    end

    always_comb begin
        win_flat_r = '0;
        for (int k = 0; k < 25; k++) begin
            win_flat_r[k*DATA_W +: DATA_W] = win[k];
        end
    end

    assign bus.win_flat   = win_flat_r;
    assign bus.win_valid  = win_valid_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_conv5_window_gen.sv
// Bench for conv5_window_gen: 28x28 instance checked against an image-array
// model of the expected windows, plus a 5x5 instance for the minimum size.
module tb_conv5_window_gen;
  localparam int W = 28;
  localparam int H = 28;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv5_window_gen_if #(.DATA_W(8)) bus_a ();
  conv5_window_gen_if #(.DATA_W(8)) bus_b ();

  conv5_window_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  conv5_window_gen #(.DATA_W(8), .IMG_W(5), .IMG_H(5)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // reference model: the frame as a 2D image plus the raster position
  logic [7:0]   img [H][W];
  int           mr, mc;
  logic [199:0] exp_q[$];
  int           checks, errors;
  int           win_cnt, fd_cnt;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [199:0] window_at(input int r, input int c);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[(i*5+j)*8 +: 8] = img[r-4+i][c-4+j];
    return w;
  endfunction

  function automatic logic [7:0] pix_for(input int mode, input int r, input int c);
    case (mode)
      0:       return 8'((r*W + c) % 256);
      1:       return 8'hAA;
      2:       return 8'h55;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    mr = 0;
    mc = 0;
    exp_q.delete();
  endtask

  // driver: one cycle on DUT A, then check every output against the model
  task automatic step_a(input logic v, input logic [7:0] p);
    logic         qual, last;
    logic [199:0] exp_w;
    qual = 1'b0;
    last = 1'b0;
    bus_a.pix_valid = v;
    bus_a.pix_in    = p;
    if (v) begin
      img[mr][mc] = p;
      if (mr >= 4 && mc >= 4) begin
        qual = 1'b1;
        exp_q.push_back(window_at(mr, mc));
      end
      last = (mr == H-1) && (mc == W-1);
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr + 1) % H;
      end
    end
    @(posedge clk);
    #1;
    bus_a.pix_valid = 1'b0;
    if (bus_a.win_valid === 1'b1) win_cnt++;
    if (bus_a.frame_done === 1'b1) fd_cnt++;
    chk("win_valid", 200'(bus_a.win_valid), 200'(qual));
    chk("frame_done", 200'(bus_a.frame_done), 200'(qual && last));
    if (qual) begin
      exp_w = exp_q.pop_front();
      chk("win_flat", bus_a.win_flat, exp_w);
    end
  endtask

  // one frame (or the part before stop_row) with optional random bubbles
  task automatic frame_a(input int mode, input int bubble_pct, input int stop_row);
    logic [7:0] p;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_row) return;
        while ($urandom_range(99, 0) < bubble_pct) step_a(1'b0, 8'($urandom));
        p = pix_for(mode, r, c);
        step_a(1'b1, p);
        if (mode == 0 && r == 4 && c == 4) begin
          chk("first_k0", 200'(bus_a.win_flat[0*8 +: 8]), 200'(0));
          chk("first_k12", 200'(bus_a.win_flat[12*8 +: 8]), 200'(58));
          chk("first_k24", 200'(bus_a.win_flat[24*8 +: 8]), 200'(116));
        end
        if (mode == 0 && r == H-1 && c == W-1) begin
          chk("last_k24", 200'(bus_a.win_flat[24*8 +: 8]), 200'((27*28 + 27) % 256));
          chk("last_k0", 200'(bus_a.win_flat[0*8 +: 8]), 200'((23*28 + 23) % 256));
        end
      end
    end
  endtask

  logic [199:0] exp_b;

  initial begin
    checks  = 0;
    errors  = 0;
    win_cnt = 0;
    fd_cnt  = 0;
    bus_a.pix_valid = 1'b0;
    bus_a.pix_in    = '0;
    bus_b.pix_valid = 1'b0;
    bus_b.pix_in    = '0;
    model_reset();

    // 1: reset held while pix_valid toggles
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_a.pix_valid = i[0];
      bus_a.pix_in    = 8'($urandom);
      bus_b.pix_valid = i[0];
      bus_b.pix_in    = 8'($urandom);
      @(posedge clk);
      #1;
      chk("rst_win_valid", 200'(bus_a.win_valid), 200'(0));
      chk("rst_frame_done", 200'(bus_a.frame_done), 200'(0));
      chk("rst_win_flat", bus_a.win_flat, 200'(0));
      chk("rst_b_win_flat", bus_b.win_flat, 200'(0));
    end
    bus_a.pix_valid = 1'b0;
    bus_b.pix_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: full frame, position pattern
    win_cnt = 0; fd_cnt = 0;
    frame_a(0, 0, -1);
    chk("t2_windows", 200'(win_cnt), 200'((W-4)*(H-4)));
    chk("t2_frame_done", 200'(fd_cnt), 200'(1));

    // 3: same frame with bubbles about half the time
    win_cnt = 0; fd_cnt = 0;
    frame_a(0, 50, -1);
    chk("t3_windows", 200'(win_cnt), 200'(576));
    chk("t3_frame_done", 200'(fd_cnt), 200'(1));
    for (int i = 0; i < 5; i++) step_a(1'b0, 8'($urandom));

    // 4: back-to-back constant frames
    win_cnt = 0; fd_cnt = 0;
    frame_a(1, 0, -1);
    frame_a(2, 0, -1);
    chk("t4_windows", 200'(win_cnt), 200'(1152));
    chk("t4_frame_done", 200'(fd_cnt), 200'(2));

    // 5: reset in the middle of a frame, then a fresh frame
    frame_a(3, 10, 10);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_win_valid", 200'(bus_a.win_valid), 200'(0));
    chk("t5_rst_win_flat", bus_a.win_flat, 200'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    win_cnt = 0; fd_cnt = 0;
    frame_a(3, 20, -1);
    chk("t5_windows", 200'(win_cnt), 200'(576));
    chk("t5_frame_done", 200'(fd_cnt), 200'(1));

    // 7: random pixels with light bubbles, two frames
    win_cnt = 0; fd_cnt = 0;
    frame_a(3, 15, -1);
    frame_a(3, 0, -1);
    chk("t7_windows", 200'(win_cnt), 200'(1152));
    chk("t7_frame_done", 200'(fd_cnt), 200'(2));

    // 6: minimum 5x5 image on the second instance
    exp_b = '0;
    for (int k = 0; k < 25; k++) exp_b[k*8 +: 8] = 8'(k);
    for (int k = 0; k < 25; k++) begin
      bus_b.pix_valid = 1'b1;
      bus_b.pix_in    = 8'(k);
      @(posedge clk);
      #1;
      bus_b.pix_valid = 1'b0;
      if (k < 24) begin
        chk("b_no_window", 200'(bus_b.win_valid), 200'(0));
      end else begin
        chk("b_win_valid", 200'(bus_b.win_valid), 200'(1));
        chk("b_frame_done", 200'(bus_b.frame_done), 200'(1));
        chk("b_win_flat", bus_b.win_flat, exp_b);
      end
    end
    @(posedge clk);
    #1;
    chk("b_pulse_len", 200'(bus_b.win_valid), 200'(0));
    chk("b_fd_pulse_len", 200'(bus_b.frame_done), 200'(0));

    chk("model_queue_empty", 200'(exp_q.size()), 200'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
